// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i multi-cycle controller.
// Opcodes, ALU/jump/write-back encodings, FSM states and the execute bundle.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    localparam logic [1:0] JMP_RST  = 2'd0;
    localparam logic [1:0] JMP_NEXT = 2'd1;
    localparam logic [1:0] JMP_TGT  = 2'd2;
    localparam logic [1:0] JMP_EXC  = 2'd3;

    localparam logic [1:0] DS_ALU = 2'd0;
    localparam logic [1:0] DS_MEM = 2'd1;
    localparam logic [1:0] DS_IMM = 2'd2;
    localparam logic [1:0] DS_PCN = 2'd3;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_TRAP
    } state_e;

    // Controls driven in EXEC, plus branch/memory qualifiers for the FSM.
    typedef struct packed {
        logic       reg_w;
        logic       alu_s;
        logic [2:0] alu_op;
        logic [1:0] dato_s;
        logic [1:0] jump;
        logic       pc_we;
        logic       csr_w;
        logic       csr_data_s;
        logic       data_read_sel;
        logic       is_branch;
        logic       br_inv;
        logic       mem;
        logic       store;
    } ex_ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of op_code/f3/f7 into the execute control bundle.
// Ports: op_code_i, f3_i, f7_i in; ctrl_o bundle, illegal_o out.
module instr_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0] op_code_i,
    input  logic [2:0] f3_i,
    input  logic       f7_i,
    output ex_ctrl_t   ctrl_o,
    output logic       illegal_o
);

    ex_ctrl_t c;
    logic     ill;

    always_comb begin
        c   = '0;
        ill = 1'b0;
        unique case (op_code_i)
            OP_REG: begin
                c.reg_w = 1'b1;
                c.pc_we = 1'b1;
                c.jump  = JMP_NEXT;
                // f7 only qualifies ADD/SUB; no SRA/alt encodings exist
                if (f7_i && f3_i != 3'b000) ill = 1'b1;
                case (f3_i)
                    3'b000:  c.alu_op = f7_i ? ALU_SUB : ALU_ADD;
                    3'b001:  c.alu_op = ALU_SLL;
                    3'b010:  c.alu_op = ALU_SLT;
                    3'b100:  c.alu_op = ALU_XOR;
                    3'b101:  c.alu_op = ALU_SRL;
                    3'b110:  c.alu_op = ALU_OR;
                    3'b111:  c.alu_op = ALU_AND;
                    default: ill = 1'b1;
                endcase
            end
            OP_IMM: begin
                c.reg_w = 1'b1;
                c.alu_s = 1'b1;
                c.pc_we = 1'b1;
                c.jump  = JMP_NEXT;
                case (f3_i)
                    3'b000:  c.alu_op = ALU_ADD;
                    3'b001:  c.alu_op = ALU_SLL;
                    3'b010:  c.alu_op = ALU_SLT;
                    3'b100:  c.alu_op = ALU_XOR;
                    3'b101: begin
                        c.alu_op = ALU_SRL;
                        ill      = f7_i; // SRAI has no ALU op
                    end
                    3'b110:  c.alu_op = ALU_OR;
                    3'b111:  c.alu_op = ALU_AND;
                    default: ill = 1'b1;
                endcase
            end
            OP_LUI: begin
                c.reg_w  = 1'b1;
                c.dato_s = DS_IMM;
                c.pc_we  = 1'b1;
                c.jump   = JMP_NEXT;
            end
            OP_JAL: begin
                c.reg_w  = 1'b1;
                c.dato_s = DS_PCN;
                c.pc_we  = 1'b1;
                c.jump   = JMP_TGT;
            end
            OP_BRANCH: begin
                c.pc_we     = 1'b1;
                c.jump      = JMP_NEXT;
                c.is_branch = 1'b1;
                // br_inv: taken when the zero flag is clear
                case (f3_i)
                    3'b000: c.alu_op = ALU_SUB;
                    3'b001: begin
                        c.alu_op = ALU_SUB;
                        c.br_inv = 1'b1;
                    end
                    3'b100: begin
                        c.alu_op = ALU_SLT;
                        c.br_inv = 1'b1;
                    end
                    3'b101:  c.alu_op = ALU_SLT;
                    default: ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                c.alu_s = 1'b1;
                c.mem   = 1'b1;
                case (f3_i)
                    3'b000, 3'b001, 3'b010,
                    3'b100, 3'b101: ill = 1'b0;
                    default:        ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                c.alu_s = 1'b1;
                c.mem   = 1'b1;
                c.store = 1'b1;
                case (f3_i)
                    3'b000, 3'b001, 3'b010: ill = 1'b0;
                    default:                ill = 1'b1;
                endcase
            end
            OP_SYSTEM: begin
                c.csr_w         = 1'b1;
                c.csr_data_s    = f3_i[2];
                c.data_read_sel = 1'b1;
                c.dato_s        = DS_MEM;
                c.reg_w         = 1'b1;
                c.pc_we         = 1'b1;
                c.jump          = JMP_NEXT;
                // only CSRRW/CSRRWI; ECALL and the rest trap
                if (f3_i != 3'b001 && f3_i != 3'b101) ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
    end

    // An illegal instruction drives nothing in EXEC.
    assign ctrl_o    = ill ? '0 : c;
    assign illegal_o = ill;

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle rv32i main controller: FETCH, EXEC, MEM, TRAP sequencing.
// Ports: decode inputs, imem/dmem handshakes, datapath controls, instret.
module control_fsm
    import rv32i_pkg::*;
#(
    parameter int RESET_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op_code,
    input  logic [2:0]  f3,
    input  logic        f7,
    input  logic        flag,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_we,
    output logic        branch,
    output logic [1:0]  jump,
    output logic [1:0]  dato_s,
    output logic        reg_w,
    output logic        alu_s,
    output logic [2:0]  alu_op,
    output logic        csr_w,
    output logic        csr_data_s,
    output logic        data_read_sel,
    output logic        trap,
    output logic [31:0] instret
);

    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);

    state_e      state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    ex_ctrl_t    ex;
    logic        illegal;

    instr_decoder u_dec (
        .op_code_i (op_code),
        .f3_i      (f3),
        .f7_i      (f7),
        .ctrl_o    (ex),
        .illegal_o (illegal)
    );

    always_comb begin
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        pc_we         = 1'b0;
        branch        = 1'b0;
        jump          = JMP_RST;
        dato_s        = DS_ALU;
        reg_w         = 1'b0;
        alu_s         = 1'b0;
        alu_op        = ALU_ADD;
        csr_w         = 1'b0;
        csr_data_s    = 1'b0;
        data_read_sel = 1'b0;
        trap          = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                pc_we = 1'b1;
                jump  = JMP_RST;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            ST_EXEC: begin
                reg_w         = ex.reg_w;
                alu_s         = ex.alu_s;
                alu_op        = ex.alu_op;
                dato_s        = ex.dato_s;
                jump          = ex.jump;
                pc_we         = ex.pc_we;
                csr_w         = ex.csr_w;
                csr_data_s    = ex.csr_data_s;
                data_read_sel = ex.data_read_sel;
                branch        = ex.is_branch & (flag ^ ex.br_inv);
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ex.store;
                alu_s    = 1'b1;
                alu_op   = ALU_ADD;
                if (dmem_ready) begin
                    pc_we = 1'b1;
                    jump  = JMP_NEXT;
                    if (!ex.store) begin
                        reg_w  = 1'b1;
                        dato_s = DS_MEM;
                    end
                end
            end
            ST_TRAP: begin
                jump  = JMP_EXC;
                pc_we = 1'b1;
                trap  = 1'b1;
            end
            default: ;
        endcase
    end

    assign instret_d = instret_q + 32'd1;
    assign instret   = instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            // RESET and TRAP PC loads are not retirements
            if (pc_we && (state_q == ST_EXEC || state_q == ST_MEM))
                instret_q <= instret_d;
            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == CNT_LAST) state_q <= ST_FETCH;
                    else cnt_q <= cnt_q + 1'b1;
                end
                ST_FETCH: if (imem_ready) state_q <= ST_EXEC;
                ST_EXEC: begin
                    if (illegal)     state_q <= ST_TRAP;
                    else if (ex.mem) state_q <= ST_MEM;
                    else             state_q <= ST_FETCH;
                end
                ST_MEM:   if (dmem_ready) state_q <= ST_FETCH;
                ST_TRAP:  state_q <= ST_FETCH;
                default:  state_q <= ST_RESET;
            endcase
        end
    end

endmodule
